phys_reg_wb_arbiter: RTL and testbench

PHYS_REG_WB_ARBITER -- requirements
Module: phys_reg_wb_arbiter

---
 rtl/phys_reg_wb_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_phys_reg_wb_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phys_reg_wb_arbiter.sv
// Writeback arbiter: per-requester FIFOs feeding two physical register file
// write ports, granted round-robin starting from rr_ptr.
module phys_reg_wb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [6*NUM_REQ-1:0]   req_reg,
    input  logic [32*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [5:0]             reg_to_update1,
    output logic [31:0]            new_value1,
    output logic                   update1,
    output logic [5:0]             reg_to_update2,
    output logic [31:0]            new_value2,
    output logic                   update2,
    output logic                   idle
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = 6 + 32;

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   rr_next;
    logic [NUM_REQ-1:0] not_empty;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    logic [ENTRY_W-1:0] head_entry [NUM_REQ];

    logic               found1;
    logic               found2;
    logic [IDX_W-1:0]   sel1;
    logic [IDX_W-1:0]   sel2;
    logic               grant_en;
    logic               grant1;
    logic               grant2;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    // Per-requester FIFO: ready is derived from the registered count only,
    // so a dequeue in the same cycle never opens a slot early.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : fifo
            logic [PTR_W-1:0]   wr_ptr_reg;
            logic [PTR_W-1:0]   rd_ptr_reg;
            logic [CNT_W-1:0]   count_reg;
            logic [ENTRY_W-1:0] mem [DEPTH];
            logic [PTR_W-1:0]   wr_ptr_next;
            logic [PTR_W-1:0]   rd_ptr_next;

            assign wr_ptr_next     = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            assign rd_ptr_next     = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            assign not_empty[gi]   = (count_reg != '0);
            assign req_ready[gi]   = (count_reg < CNT_W'(DEPTH));
            assign push[gi]        = req_valid[gi] && req_ready[gi] && !flush;
            assign head_entry[gi]  = mem[rd_ptr_reg];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else if (flush) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push[gi]) begin
                        wr_ptr_reg <= wr_ptr_next;
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_next;
                    end
                    case ({push[gi], pop[gi]})
                        2'b10:   count_reg <= count_reg + 1'b1;
                        2'b01:   count_reg <= count_reg - 1'b1;
                        default: count_reg <= count_reg;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem[wr_ptr_reg] <= {req_reg[6*gi +: 6], req_data[32*gi +: 32]};
                end
            end
        end
    endgenerate

    // First two non-empty heads scanning upward from rr_ptr.
    always_comb begin
        logic [IDX_W-1:0] idx;
        found1 = 1'b0;
        found2 = 1'b0;
        sel1   = '0;
        sel2   = '0;
        idx    = '0;
        for (int o = 0; o < NUM_REQ; o++) begin
            idx = IDX_W'((int'(rr_ptr) + o) % NUM_REQ);
            if (not_empty[idx]) begin
                if (!found1) begin
                    found1 = 1'b1;
                    sel1   = idx;
                end else if (!found2) begin
                    found2 = 1'b1;
                    sel2   = idx;
                end
            end
        end
    end

    assign grant_en = !stall && !flush;
    assign grant1   = grant_en && found1;
    assign grant2   = grant_en && found2;

    always_comb begin
        pop = '0;
        if (grant1) begin
            pop[sel1] = 1'b1;
        end
        if (grant2) begin
            pop[sel2] = 1'b1;
        end
    end

    always_comb begin
        rr_next = rr_ptr;
        if (flush) begin
            rr_next = '0;
        end else if (grant2) begin
            rr_next = next_idx(sel2);
        end else if (grant1) begin
            rr_next = next_idx(sel1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_next;
        end
    end

    // Register 0 is hardwired, so its writes are consumed without a pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            update1        <= 1'b0;
            update2        <= 1'b0;
            reg_to_update1 <= '0;
            new_value1     <= '0;
            reg_to_update2 <= '0;
            new_value2     <= '0;
        end else if (!grant_en) begin
            update1 <= 1'b0;
            update2 <= 1'b0;
        end else begin
            update1 <= grant1 && (head_entry[sel1][37:32] != 6'd0);
            update2 <= grant2 && (head_entry[sel2][37:32] != 6'd0);
            if (grant1) begin
                {reg_to_update1, new_value1} <= head_entry[sel1];
            end
            if (grant2) begin
                {reg_to_update2, new_value2} <= head_entry[sel2];
            end
        end
    end

    assign idle = (not_empty == '0) && !update1 && !update2;

endmodule

// File: tb/tb_phys_reg_wb_arbiter.sv
// Directed bench for phys_reg_wb_arbiter with hand-computed expectations.
module tb_phys_reg_wb_arbiter;

    logic         clk;
    logic         reset;
    logic         stall;
    logic         flush;
    logic [3:0]   req_valid;
    logic [23:0]  req_reg;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic [5:0]   reg_to_update1;
    logic [31:0]  new_value1;
    logic         update1;
    logic [5:0]   reg_to_update2;
    logic [31:0]  new_value2;
    logic         update2;
    logic         idle;

    int checks   = 0;
    int failures = 0;
    int upd_cnt  = 0;

    phys_reg_wb_arbiter #(.NUM_REQ(4), .DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .req_valid      (req_valid),
        .req_reg        (req_reg),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .reg_to_update1 (reg_to_update1),
        .new_value1     (new_value1),
        .update1        (update1),
        .reg_to_update2 (reg_to_update2),
        .new_value2     (new_value2),
        .update2        (update2),
        .idle           (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [5:0] r, input logic [31:0] d);
        req_reg[6*i +: 6]   = r;
        req_data[32*i +: 32] = d;
    endtask

    task automatic check_port1(input string tag, input logic u, input logic [5:0] r, input logic [31:0] v);
        check_val({tag, ".upd1"}, update1, u);
        check_val({tag, ".reg1"}, reg_to_update1, r);
        check_val({tag, ".val1"}, new_value1, v);
    endtask

    task automatic check_port2(input string tag, input logic u, input logic [5:0] r, input logic [31:0] v);
        check_val({tag, ".upd2"}, update2, u);
        check_val({tag, ".reg2"}, reg_to_update2, r);
        check_val({tag, ".val2"}, new_value2, v);
    endtask

    initial begin
        reset     = 1'b1;
        stall     = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        req_reg   = '0;
        req_data  = '0;
        #3;
        check_val("rst.ready", req_ready, 4'b1111);
        check_val("rst.idle", idle, 1'b1);
        check_port1("rst", 1'b0, 6'd0, 32'd0);
        check_port2("rst", 1'b0, 6'd0, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Single request from requester 2
        req_valid = 4'b0100;
        set_req(2, 6'd5, 32'hDEADBEEF);
        tick();
        req_valid = '0;
        check_val("single.early_upd1", update1, 1'b0);
        check_val("single.busy", idle, 1'b0);
        tick();
        check_port1("single", 1'b1, 6'd5, 32'hDEADBEEF);
        check_val("single.upd2", update2, 1'b0);
        tick();
        check_val("single.upd1_off", update1, 1'b0);
        check_val("single.idle", idle, 1'b1);

        // Four requesters, two entries each, starting from rr_ptr=0
        flush = 1'b1;
        tick();
        flush = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) set_req(i, 6'(1 + i), 32'hA000_0000 | (i << 4));
        tick();
        for (int i = 0; i < 4; i++) set_req(i, 6'(5 + i), 32'hA000_0000 | (i << 4) | 1);
        tick();
        req_valid = '0;
        upd_cnt = 0;
        for (int p = 0; p < 4; p++) begin
            int a;
            int b;
            int e;
            a = (p % 2) * 2;
            b = a + 1;
            e = p / 2;
            check_port1($sformatf("all4.p%0d", p), 1'b1, 6'(1 + a + 4 * e), 32'hA000_0000 | (a << 4) | e);
            check_port2($sformatf("all4.p%0d", p), 1'b1, 6'(1 + b + 4 * e), 32'hA000_0000 | (b << 4) | e);
            upd_cnt += int'(update1) + int'(update2);
            tick();
        end
        check_val("all4.updates", upd_cnt, 8);
        check_val("all4.idle", idle, 1'b1);

        // Backpressure on requester 1 while stalled
        stall = 1'b1;
        req_valid = 4'b0010;
        set_req(1, 6'd9, 32'h101);
        check_val("bp.ready_c1", req_ready[1], 1'b1);
        tick();
        set_req(1, 6'd9, 32'h102);
        check_val("bp.ready_c2", req_ready[1], 1'b1);
        tick();
        set_req(1, 6'd9, 32'h103);
        check_val("bp.ready_c3", req_ready[1], 1'b0);
        check_val("bp.stall_upd", update1, 1'b0);
        tick();
        req_valid = '0;
        check_val("bp.still_full", req_ready[1], 1'b0);
        stall = 1'b0;
        tick();
        check_port1("bp.d1", 1'b1, 6'd9, 32'h101);
        check_val("bp.d1.upd2", update2, 1'b0);
        check_val("bp.ready_back", req_ready[1], 1'b1);
        tick();
        check_port1("bp.d2", 1'b1, 6'd9, 32'h102);
        tick();
        check_val("bp.no_third", update1, 1'b0);
        check_val("bp.idle", idle, 1'b1);

        // Register 0 entry is consumed without an update pulse
        req_valid = 4'b1000;
        set_req(3, 6'd0, 32'h1234);
        tick();
        req_valid = '0;
        tick();
        check_port1("reg0", 1'b0, 6'd0, 32'h1234);
        check_val("reg0.ready3", req_ready[3], 1'b1);
        check_val("reg0.empty", idle, 1'b1);

        // Move rr_ptr to 2, then buffer 5 entries and flush
        req_valid = 4'b0010;
        set_req(1, 6'd10, 32'h55);
        tick();
        req_valid = '0;
        tick();
        check_port1("pre_flush", 1'b1, 6'd10, 32'h55);
        stall = 1'b1;
        req_valid = 4'b0111;
        for (int i = 0; i < 3; i++) set_req(i, 6'(20 + i), 32'hF00 + i);
        tick();
        req_valid = 4'b0011;
        tick();
        req_valid = '0;
        check_val("flush.ready_before", req_ready, 4'b1100);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        check_val("flush.ready", req_ready, 4'b1111);
        check_val("flush.upd1", update1, 1'b0);
        check_val("flush.upd2", update2, 1'b0);
        check_val("flush.idle", idle, 1'b1);
        // With rr_ptr back at 0, requester 1 wins port 1 over requester 3
        req_valid = 4'b1010;
        set_req(1, 6'd31, 32'h311);
        set_req(3, 6'd33, 32'h333);
        tick();
        req_valid = '0;
        tick();
        check_port1("flush.rr", 1'b1, 6'd31, 32'h311);
        check_port2("flush.rr", 1'b1, 6'd33, 32'h333);
        tick();
        check_val("flush.rr_idle", idle, 1'b1);

        // Reset asserted mid-drain
        stall = 1'b1;
        req_valid = 4'b0111;
        for (int i = 0; i < 3; i++) set_req(i, 6'(40 + i), 32'hB00 + i);
        tick();
        tick();
        req_valid = '0;
        stall = 1'b0;
        tick();
        check_port1("mid.pre", 1'b1, 6'd40, 32'hB00);
        #2;
        reset = 1'b1;
        #1;
        check_port1("mid.rst", 1'b0, 6'd0, 32'd0);
        check_port2("mid.rst", 1'b0, 6'd0, 32'd0);
        check_val("mid.ready", req_ready, 4'b1111);
        check_val("mid.idle", idle, 1'b1);
        tick();
        reset = 1'b0;
        upd_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            upd_cnt += int'(update1) + int'(update2);
        end
        check_val("mid.no_updates", upd_cnt, 0);
        check_val("mid.idle_after", idle, 1'b1);

        // Fairness: requester 0 always valid, 1-3 present one entry each
        req_valid = 4'b1111;
        set_req(0, 6'd50, 32'hC0);
        set_req(1, 6'd51, 32'hD1);
        set_req(2, 6'd52, 32'hD2);
        set_req(3, 6'd53, 32'hD3);
        tick();
        req_valid = 4'b0001;
        set_req(0, 6'd54, 32'hC1);
        tick();
        check_port1("fair.c1", 1'b1, 6'd50, 32'hC0);
        check_port2("fair.c1", 1'b1, 6'd51, 32'hD1);
        set_req(0, 6'd55, 32'hC2);
        tick();
        req_valid = '0;
        check_port1("fair.c2", 1'b1, 6'd52, 32'hD2);
        check_port2("fair.c2", 1'b1, 6'd53, 32'hD3);
        tick();
        check_port1("fair.c3", 1'b1, 6'd54, 32'hC1);
        check_val("fair.c3.upd2", update2, 1'b0);
        tick();
        check_port1("fair.c4", 1'b1, 6'd55, 32'hC2);
        tick();
        check_val("fair.idle", idle, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
